// File: rtl/eco_pkg.sv
// Shared types and sizing helpers for the ECO equivalence-sweep harness blocks.
package eco_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int DEF_W      = 4;
  localparam int DEF_SETTLE = 1;

  // Sweep vector holds both operands; the mismatch counter must reach 2^(2W).
  function automatic int vec_w(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive operand sweep comparing original vs ECO-patched datapath outputs,
// counting mismatches and capturing the first failing vector.
module eco_sweep_ctrl
  import eco_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int SETTLE       = DEF_SETTLE,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [W-1:0]          dut_a,
  output logic [W-1:0]          dut_b,
  input  logic [W-1:0]          ref_y,
  input  logic [W-1:0]          eco_y,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  aborted,
  output logic [cnt_w(W)-1:0]   mismatch_cnt,
  output logic [W-1:0]          fail_a,
  output logic [W-1:0]          fail_b,
  output logic [W-1:0]          fail_ref_y,
  output logic [W-1:0]          fail_eco_y
);

  localparam int VW   = vec_w(W);
  localparam int CW   = cnt_w(W);
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          state;
  logic [VW-1:0]   vec;
  logic [SC_W-1:0] sc;
  logic            miss;
  logic [CW-1:0]   cnt_nxt;

  always_comb begin
    miss    = (ref_y != eco_y);
    cnt_nxt = mismatch_cnt + CW'(miss);
  end

  assign dut_a = vec[VW-1:W];
  assign dut_b = vec[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      vec          <= '0;
      sc           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      aborted      <= 1'b0;
      mismatch_cnt <= '0;
      fail_a       <= '0;
      fail_b       <= '0;
      fail_ref_y   <= '0;
      fail_eco_y   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= S_SETTLE;
            vec          <= '0;
            sc           <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            aborted      <= 1'b0;
            mismatch_cnt <= '0;
            fail_a       <= '0;
            fail_b       <= '0;
            fail_ref_y   <= '0;
            fail_eco_y   <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            pass    <= 1'b0;
          end else if (sc == SC_W'(SETTLE - 1)) begin
            state <= S_COMPARE;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_COMPARE: begin
          // Abort wins: this cycle's comparison is dropped entirely.
          if (abort) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            pass    <= 1'b0;
          end else begin
            mismatch_cnt <= cnt_nxt;
            if (miss && mismatch_cnt == '0) begin
              fail_a     <= vec[VW-1:W];
              fail_b     <= vec[W-1:0];
              fail_ref_y <= ref_y;
              fail_eco_y <= eco_y;
            end
            if ((miss && STOP_ON_FAIL) || (vec == '1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cnt_nxt == '0);
            end else begin
              state <= S_SETTLE;
              vec   <= vec + 1'b1;
              sc    <= '0;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
